// File: rtl/level_sensor_conditioner.sv
// rtl/level_sensor_conditioner.sv - float-switch synchroniser, debouncer and level validity FSM
//
// Conditions three raw float-switch inputs (thermometer code, bit0 = lowest)
// into a clean, held fill level for the pump logic.
//
// Ports:
//   clk     in  1  system clock
//   rst_n   in  1  asynchronous active-low reset
//   x_raw   in  3  raw level sensors, asynchronous to clk, 1 = wet
//   level   out 3  conditioned level: 000, 001, 011 or 111 only
//   valid   out 1  level is trustworthy (pumps run only while high)
//   fault   out 1  sticky illegal-pattern fault, cleared only by reset
//   change  out 1  one-cycle pulse in the first cycle a new level is shown
module level_sensor_conditioner #(
    parameter int DEB_CYCLES   = 16,
    parameter int FAULT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] x_raw,
    output logic [2:0] level,
    output logic       valid,
    output logic       fault,
    output logic       change
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int IW = $clog2(DEB_CYCLES + 3);
    localparam int FW = $clog2(FAULT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_OK,
        ST_SUSPECT,
        ST_FAULT
    } state_t;

    state_t state, state_d;

    logic [2:0]           s1, s2, stable;
    logic [2:0][DW-1:0]   deb_cnt;
    logic [IW-1:0]        init_cnt, init_cnt_d;
    logic [FW-1:0]        fault_cnt, fault_cnt_d;
    logic [2:0]           level_d;
    logic                 valid_d, fault_d, change_d;
    logic                 stable_legal;

    // Two-flop synchroniser per bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 3'b000;
            s2 <= 3'b000;
        end else begin
            s1 <= x_raw;
            s2 <= s1;
        end
    end

    // Per-bit debounce. Any cycle of agreement clears the count, so only an
    // unbroken run of DEB_CYCLES disagreeing samples moves the stable bit.
    // The count is cleared on acceptance and therefore never exceeds
    // DEB_CYCLES-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt <= '0;
            stable  <= 3'b000;
        end else begin
            for (int b = 0; b < 3; b++) begin
                if (s2[b] == stable[b]) begin
                    deb_cnt[b] <= '0;
                end else if (deb_cnt[b] == DW'(DEB_CYCLES - 1)) begin
                    stable[b]  <= s2[b];
                    deb_cnt[b] <= '0;
                end else begin
                    deb_cnt[b] <= deb_cnt[b] + 1'b1;
                end
            end
        end
    end

    assign stable_legal = (stable == 3'b000) || (stable == 3'b001) ||
                          (stable == 3'b011) || (stable == 3'b111);

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            fault_cnt <= '0;
            level     <= 3'b000;
            valid     <= 1'b0;
            fault     <= 1'b0;
            change    <= 1'b0;
        end else begin
            state     <= state_d;
            init_cnt  <= init_cnt_d;
            fault_cnt <= fault_cnt_d;
            level     <= level_d;
            valid     <= valid_d;
            fault     <= fault_d;
            change    <= change_d;
        end
    end

    always_comb begin
        state_d     = state;
        init_cnt_d  = init_cnt;
        fault_cnt_d = fault_cnt;
        level_d     = level;
        valid_d     = valid;
        fault_d     = fault;
        change_d    = 1'b0;
        case (state)
            ST_INIT: begin
                // Wait long enough for the debouncers to settle on the
                // first real sample before trusting the stable word.
                init_cnt_d = init_cnt + 1'b1;
                if (init_cnt == IW'(DEB_CYCLES + 1)) begin
                    init_cnt_d = '0;
                    if (stable_legal) begin
                        state_d = ST_OK;
                        level_d = stable;
                        valid_d = 1'b1;
                    end else begin
                        state_d     = ST_SUSPECT;
                        fault_cnt_d = FW'(1);
                    end
                end
            end
            ST_OK: begin
                if (stable_legal) begin
                    level_d  = stable;
                    change_d = (stable != level);
                end else begin
                    state_d     = ST_SUSPECT;
                    fault_cnt_d = FW'(1);
                end
            end
            ST_SUSPECT: begin
                // Legal check comes first so a pattern settling on the
                // terminal cycle still recovers instead of faulting.
                if (stable_legal) begin
                    state_d     = ST_OK;
                    level_d     = stable;
                    valid_d     = 1'b1;
                    fault_cnt_d = '0;
                    change_d    = (stable != level);
                end else if (fault_cnt == FW'(FAULT_CYCLES - 1)) begin
                    state_d     = ST_FAULT;
                    valid_d     = 1'b0;
                    fault_d     = 1'b1;
                    fault_cnt_d = FW'(FAULT_CYCLES);
                end else begin
                    fault_cnt_d = fault_cnt + 1'b1;
                end
            end
            ST_FAULT: begin
                valid_d = 1'b0;
                fault_d = 1'b1;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_level_sensor_conditioner.sv
// tb/tb_level_sensor_conditioner.sv - self-checking bench for level_sensor_conditioner
module tb_level_sensor_conditioner;

    localparam int DEB = 4;
    localparam int FC  = 8;

    localparam int MODE_INIT    = 0;
    localparam int MODE_OK      = 1;
    localparam int MODE_SUSPECT = 2;
    localparam int MODE_FAULT   = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] x_raw;
    logic [2:0] level;
    logic       valid;
    logic       fault;
    logic       change;

    level_sensor_conditioner #(
        .DEB_CYCLES   (DEB),
        .FAULT_CYCLES (FC)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .x_raw  (x_raw),
        .level  (level),
        .valid  (valid),
        .fault  (fault),
        .change (change)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_change = 0;

    // Reference model state.
    logic [2:0] m_s1, m_s2, m_stable, m_level;
    logic       m_valid, m_fault, m_change;
    logic [2:0] m_hist[$];
    int         m_mode, m_init_edges, m_run;

    typedef struct {
        logic [2:0] x;
        int         hold;
        logic [2:0] exp_level;
        logic       exp_valid;
        logic       exp_fault;
        int         exp_lat;
    } vec_t;

    vec_t sweep[6];

    function automatic bit is_legal(input logic [2:0] v);
        return (v == 3'b000) || (v == 3'b001) || (v == 3'b011) || (v == 3'b111);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_level = '0;
        m_valid = 1'b0; m_fault = 1'b0; m_change = 1'b0;
        m_hist.delete();
        m_mode = MODE_INIT; m_init_edges = 0; m_run = 0;
    endtask

    // One rising edge of the reference: the level logic reacts to the stable
    // word as it was before the edge; stable bits flip once the last DEB
    // synchronised samples all disagree with them.
    task automatic model_edge(input logic [2:0] x);
        logic [2:0] st;
        bit         all_diff;
        st = m_stable;
        m_change = 1'b0;
        case (m_mode)
            MODE_INIT: begin
                m_init_edges++;
                if (m_init_edges == DEB + 2) begin
                    if (is_legal(st)) begin
                        m_mode = MODE_OK; m_level = st; m_valid = 1'b1;
                    end else begin
                        m_mode = MODE_SUSPECT; m_run = 1;
                    end
                end
            end
            MODE_OK: begin
                if (is_legal(st)) begin
                    m_change = (st != m_level); m_level = st;
                end else begin
                    m_mode = MODE_SUSPECT; m_run = 1;
                end
            end
            MODE_SUSPECT: begin
                if (is_legal(st)) begin
                    m_change = (st != m_level); m_level = st;
                    m_valid = 1'b1; m_mode = MODE_OK; m_run = 0;
                end else begin
                    m_run++;
                    if (m_run >= FC) begin
                        m_mode = MODE_FAULT; m_valid = 1'b0; m_fault = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        m_hist.push_back(m_s2);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        if (m_hist.size() == DEB) begin
            for (int b = 0; b < 3; b++) begin
                all_diff = 1'b1;
                foreach (m_hist[i]) if (m_hist[i][b] == m_stable[b]) all_diff = 1'b0;
                if (all_diff) m_stable[b] = ~m_stable[b];
            end
        end
        m_s2 = m_s1;
        m_s1 = x;
    endtask

    task automatic step(input logic [2:0] x);
        x_raw = x;
        @(posedge clk);
        model_edge(x);
        #1;
        if (change) n_change++;
        check("cycle{level,valid,fault,change}",
              int'({level, valid, fault, change}),
              int'({m_level, m_valid, m_fault, m_change}));
    endtask

    // Reset asserted mid-cycle; outputs must clear before the next edge.
    task automatic do_reset(input int cyc);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_reset", int'({level, valid, fault, change}), 0);
        repeat (cyc) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int         lat;
        bit         saw;
        bit         valid_dropped;
        logic [2:0] x;
        logic [2:0] legal_vals[4];
        int         hold;

        legal_vals = '{3'b000, 3'b001, 3'b011, 3'b111};
        sweep[0] = '{3'b001, 20, 3'b001, 1'b1, 1'b0, 7};
        sweep[1] = '{3'b011, 20, 3'b011, 1'b1, 1'b0, 7};
        sweep[2] = '{3'b111, 20, 3'b111, 1'b1, 1'b0, 7};
        sweep[3] = '{3'b011, 20, 3'b011, 1'b1, 1'b0, 7};
        sweep[4] = '{3'b001, 20, 3'b001, 1'b1, 1'b0, 7};
        sweep[5] = '{3'b000, 20, 3'b000, 1'b1, 1'b0, 7};

        rst_n = 1'b1;
        x_raw = 3'b000;
        model_reset();

        // Reset and init window.
        do_reset(3);
        n_change = 0;
        for (int i = 1; i <= 5; i++) begin
            step(3'b000);
            check("init_valid_low", valid, 0);
        end
        step(3'b000);
        check("init_valid_high", valid, 1);
        check("init_level", level, 0);
        check("init_no_change", n_change, 0);

        // Level sweep with latency per step.
        n_change = 0;
        foreach (sweep[k]) begin
            lat = -1;
            for (int j = 1; j <= sweep[k].hold; j++) begin
                step(sweep[k].x);
                if (lat < 0 && level == sweep[k].x) lat = j;
            end
            check("sweep_level", level, sweep[k].exp_level);
            check("sweep_valid", valid, sweep[k].exp_valid);
            check("sweep_fault", fault, sweep[k].exp_fault);
            check("sweep_latency", lat, sweep[k].exp_lat);
        end
        check("sweep_changes", n_change, 6);

        // Glitch rejection at 011.
        repeat (20) step(3'b011);
        n_change = 0;
        repeat (3) step(3'b111);
        repeat (20) step(3'b011);
        check("glitch3_level", level, 3'b011);
        check("glitch3_changes", n_change, 0);
        saw = 1'b0;
        for (int j = 0; j < 7; j++) begin
            step(3'b111);
            if (level == 3'b111) saw = 1'b1;
        end
        for (int j = 0; j < 20; j++) begin
            step(3'b011);
            if (level == 3'b111) saw = 1'b1;
        end
        check("glitch7_reached_111", saw, 1);
        check("glitch7_level", level, 3'b011);
        check("glitch7_changes", n_change, 2);

        // Transient illegal pattern from 001.
        repeat (20) step(3'b001);
        n_change = 0;
        valid_dropped = 1'b0;
        for (int j = 0; j < 26; j++) begin
            step(j < 6 ? 3'b101 : 3'b011);
            if (!valid || fault) valid_dropped = 1'b1;
        end
        check("transient_level", level, 3'b011);
        check("transient_valid_held", valid_dropped, 0);
        check("transient_changes", n_change, 1);

        // Persistent illegal pattern -> FAULT exactly FC cycles after stable turns illegal.
        repeat (20) step(3'b011);
        for (int j = 1; j <= 30; j++) begin
            step(3'b010);
            if (j == 13) begin
                check("fault_not_yet", fault, 0);
                check("fault_valid_before", valid, 1);
            end
            if (j == 14) begin
                check("fault_asserted", fault, 1);
                check("fault_valid_low", valid, 0);
                check("fault_level_held", level, 3'b011);
            end
        end
        repeat (20) step(3'b011);
        check("fault_sticky", fault, 1);
        check("fault_sticky_valid", valid, 0);
        check("fault_sticky_level", level, 3'b011);

        // Reset during FAULT, then normal init.
        do_reset(2);
        repeat (10) step(3'b000);
        check("post_fault_reset_valid", valid, 1);
        check("post_fault_reset_fault", fault, 0);

        // Reset mid-debounce.
        repeat (3) step(3'b111);
        do_reset(2);
        repeat (12) step(3'b000);
        check("post_deb_reset_level", level, 3'b000);
        check("post_deb_reset_valid", valid, 1);

        // Randomised segments against the model.
        for (int seg = 0; seg < 150; seg++) begin
            if (seg % 30 == 0) do_reset(1 + $urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0) x = legal_vals[$urandom_range(0, 3)];
            else x = 3'($urandom_range(0, 7));
            hold = $urandom_range(1, 25);
            repeat (hold) step(x);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
